sr_cmd_gen: RTL and testbench

Upstream command stage for sr_flip_flop. It takes raw, bouncy set/clear push-button levels and synchronises and debounces them. It converts each press into a single-cycle s or r pulse that is never asserted together with the other, which removes the s=r=1 (x) case from the downstream flop. It also auto-clears the flop after a programmable hold time and flags when the flop's q feedback disagrees with the commanded state.

---
 rtl/sr_cmd_gen_pkg.sv | 19 +
 rtl/btn_debounce.sv | 56 +++++
 rtl/sr_cmd_gen.sv | 127 ++++++++++++
 tb/tb_sr_cmd_gen.sv | 251 +++++++++++++++++++++++++
 4 files changed

// File: rtl/sr_cmd_gen_pkg.sv
// Shared definitions for the sr_flip_flop command generator: FSM encoding and
// default timing constants used by the generator and its integration.
package sr_cmd_gen_pkg;

    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StSetP = 2'd1,
        StHold = 2'd2,
        StClrP = 2'd3
    } sr_state_e;

    localparam int unsigned DefDebounce = 4;
    localparam int unsigned DefTimeout  = 16;

    function automatic int unsigned max_u(input int unsigned a, input int unsigned b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/btn_debounce.sv
// One push-button channel: 2-flop synchroniser, stability counter and a
// one-cycle pulse on each accepted rising level.
module btn_debounce
    import sr_cmd_gen_pkg::*;
#(
    parameter int unsigned DEBOUNCE = DefDebounce,
    parameter int unsigned CNT_W    = 8
) (
    input  logic clk,
    input  logic rst,
    input  logic raw,
    output logic level,
    output logic rise
);

    logic [1:0]       sync_q;
    logic             synced;
    logic             level_q, level_d;
    logic             rise_q, rise_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    assign synced = sync_q[1];

    always_comb begin
        cnt_d   = '0;
        level_d = level_q;
        rise_d  = 1'b0;
        if (synced != level_q) begin
            // The DEBOUNCE-th differing cycle accepts the new level.
            if (cnt_q == CNT_W'(DEBOUNCE - 1)) begin
                level_d = synced;
                rise_d  = synced;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sync_q  <= '0;
            level_q <= 1'b0;
            rise_q  <= 1'b0;
            cnt_q   <= '0;
        end else begin
            sync_q  <= {sync_q[0], raw};
            level_q <= level_d;
            rise_q  <= rise_d;
            cnt_q   <= cnt_d;
        end
    end

    assign level = level_q;
    assign rise  = rise_q;

endmodule

// File: rtl/sr_cmd_gen.sv
// Turns debounced set/clear button presses into exclusive one-cycle s/r pulses
// for an sr_flip_flop, auto-clears after a hold time and checks q feedback.
module sr_cmd_gen
    import sr_cmd_gen_pkg::*;
#(
    parameter int unsigned DEBOUNCE = DefDebounce,
    parameter int unsigned TIMEOUT  = DefTimeout,
    parameter int unsigned CNT_W    = 8
) (
    input  logic clk,
    input  logic rst,
    input  logic set_btn,
    input  logic clr_btn,
    input  logic q_fb,
    output logic s,
    output logic r,
    output logic holding,
    output logic err
);

    if (DEBOUNCE < 2 || TIMEOUT < 2 ||
        CNT_W < $clog2(max_u(DEBOUNCE, TIMEOUT) + 1)) begin : gen_param_check
        $error("sr_cmd_gen: DEBOUNCE/TIMEOUT below 2 or CNT_W too narrow");
    end

    logic set_req, clr_req;
    logic set_level, clr_level;

    btn_debounce #(
        .DEBOUNCE (DEBOUNCE),
        .CNT_W    (CNT_W)
    ) u_set_db (
        .clk   (clk),
        .rst   (rst),
        .raw   (set_btn),
        .level (set_level),
        .rise  (set_req)
    );

    btn_debounce #(
        .DEBOUNCE (DEBOUNCE),
        .CNT_W    (CNT_W)
    ) u_clr_db (
        .clk   (clk),
        .rst   (rst),
        .raw   (clr_btn),
        .level (clr_level),
        .rise  (clr_req)
    );

    // Only the request pulses drive the FSM; the levels are kept for debug.
    logic unused_levels;
    assign unused_levels = set_level ^ clr_level;

    sr_state_e        state_q, state_d;
    logic [CNT_W-1:0] timer_q, timer_d;
    logic             s_q, r_q, holding_q, err_q;
    logic             err_d;

    always_comb begin
        state_d = state_q;
        timer_d = timer_q;
        unique case (state_q)
            StIdle: begin
                if (clr_req) begin
                    state_d = StClrP;
                end else if (set_req) begin
                    state_d = StSetP;
                end
            end
            StSetP: begin
                if (clr_req) begin
                    state_d = StClrP;
                end else begin
                    state_d = StHold;
                    timer_d = '0;
                end
            end
            StHold: begin
                if (clr_req) begin
                    state_d = StClrP;
                end else if (set_req) begin
                    timer_d = '0;
                end else if (timer_q == CNT_W'(TIMEOUT - 1)) begin
                    state_d = StClrP;
                end else begin
                    timer_d = timer_q + 1'b1;
                end
            end
            StClrP: begin
                // A clear press landing here still wins over a coincident set.
                if (set_req && !clr_req) begin
                    state_d = StSetP;
                end else begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    assign err_d = err_q | ((state_q == StHold) & ~q_fb);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= StIdle;
            timer_q   <= '0;
            s_q       <= 1'b0;
            r_q       <= 1'b0;
            holding_q <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            timer_q   <= timer_d;
            s_q       <= (state_d == StSetP);
            r_q       <= (state_d == StClrP);
            holding_q <= (state_d == StHold);
            err_q     <= err_d;
        end
    end

    assign s       = s_q;
    assign r       = r_q;
    assign holding = holding_q;
    assign err     = err_q;

endmodule

// File: tb/tb_sr_cmd_gen.sv
// Bench for sr_cmd_gen: directed scenarios plus randomized buttons, all
// compared every cycle against a behavioural model of the command stage.
module tb_sr_cmd_gen;

    localparam int unsigned DEBOUNCE = 4;
    localparam int unsigned TIMEOUT  = 16;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic set_btn = 1'b1;
    logic clr_btn = 1'b0;
    logic force_q0 = 1'b0;
    logic q_fb;
    logic s, r, holding, err;

    always #5 clk = ~clk;

    sr_cmd_gen #(
        .DEBOUNCE (DEBOUNCE),
        .TIMEOUT  (TIMEOUT),
        .CNT_W    (8)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .set_btn (set_btn),
        .clr_btn (clr_btn),
        .q_fb    (q_fb),
        .s       (s),
        .r       (r),
        .holding (holding),
        .err     (err)
    );

    // Downstream sr_flip_flop, optionally overridden to model a stuck q.
    logic flop_q = 1'b0;
    always @(posedge clk) begin
        if (s)      flop_q <= 1'b1;
        else if (r) flop_q <= 1'b0;
    end
    assign q_fb = force_q0 ? 1'b0 : flop_q;

    // Behavioural model: pins delayed two samples, a level is accepted after
    // DEBOUNCE consecutive disagreeing samples, then a pulse/hold countdown.
    logic d1 [2] = '{1'b0, 1'b0};
    logic d2 [2] = '{1'b0, 1'b0};
    logic lvl[2] = '{1'b0, 1'b0};
    logic req[2] = '{1'b0, 1'b0};
    int   run[2] = '{0, 0};
    logic m_s = 1'b0, m_r = 1'b0, m_err = 1'b0;
    int   hold_left = 0;

    always @(posedge clk) begin
        logic pin [2];
        logic ns, nr;
        int   nh;
        pin[0] = set_btn;
        pin[1] = clr_btn;
        if (rst) begin
            for (int b = 0; b < 2; b++) begin
                d1[b] = 1'b0; d2[b] = 1'b0; lvl[b] = 1'b0; req[b] = 1'b0; run[b] = 0;
            end
            m_s = 1'b0; m_r = 1'b0; m_err = 1'b0; hold_left = 0;
        end else begin
            if (hold_left > 0 && !q_fb) m_err = 1'b1;
            ns = 1'b0;
            nr = 1'b0;
            nh = hold_left;
            if (m_r) begin
                ns = req[0] && !req[1];
                nh = 0;
            end else if (req[1]) begin
                nr = 1'b1;
                nh = 0;
            end else if (m_s) begin
                nh = TIMEOUT;
            end else if (hold_left > 0) begin
                if (req[0]) nh = TIMEOUT;
                else if (hold_left == 1) begin nr = 1'b1; nh = 0; end
                else nh = hold_left - 1;
            end else if (req[0]) begin
                ns = 1'b1;
            end
            m_s = ns; m_r = nr; hold_left = nh;
            for (int b = 0; b < 2; b++) begin
                logic nreq;
                nreq = 1'b0;
                if (d2[b] != lvl[b]) begin
                    run[b]++;
                    if (run[b] == int'(DEBOUNCE)) begin
                        lvl[b] = d2[b];
                        run[b] = 0;
                        nreq = d2[b];
                    end
                end else begin
                    run[b] = 0;
                end
                req[b] = nreq;
                d2[b] = d1[b];
                d1[b] = pin[b];
            end
        end
    end

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check_val(input string tag, input int got, input int exp);
        n_checks++;
        if (got != exp) begin
            n_fail++;
            if (n_fail <= 40)
                $display("FAIL %s: got %0d, expected %0d at %0t", tag, got, exp, $time);
        end
    endtask

    int step_idx, n_s, first_s, n_r, first_r, n_hold;

    task automatic clear_tally();
        step_idx = 0; n_s = 0; first_s = -1; n_r = 0; first_r = -1; n_hold = 0;
    endtask

    // One clock: inputs were set before the posedge, outputs sampled at negedge.
    task automatic step();
        @(negedge clk);
        step_idx++;
        check_val("s", int'(s), int'(m_s));
        check_val("r", int'(r), int'(m_r));
        check_val("holding", int'(holding), int'(hold_left > 0));
        check_val("err", int'(err), int'(m_err));
        check_val("s_r_exclusive", int'(s & r), 0);
        if (s) begin n_s++; if (first_s < 0) first_s = step_idx; end
        if (r) begin n_r++; if (first_r < 0) first_r = step_idx; end
        if (holding) n_hold++;
    endtask

    initial begin
        int   left[2];
        logic pinv[2];

        // Reset held with set pressed.
        clear_tally();
        repeat (3) step();
        check_val("reset_s", int'(s), 0);
        check_val("reset_r", int'(r), 0);
        check_val("reset_holding", int'(holding), 0);
        check_val("reset_err", int'(err), 0);
        rst = 1'b0;
        set_btn = 1'b0;
        clear_tally();
        repeat (10) step();
        check_val("after_reset_s_pulses", n_s, 0);

        // Clean set press with a real flop on q_fb.
        clear_tally();
        set_btn = 1'b1;
        repeat (30) step();
        set_btn = 1'b0;
        repeat (10) step();
        check_val("clean_s_count", n_s, 1);
        check_val("clean_s_latency", first_s, 7);
        check_val("clean_hold_cycles", n_hold, int'(TIMEOUT));
        check_val("clean_r_count", n_r, 1);
        check_val("clean_r_cycle", first_r, 24);
        check_val("clean_err", int'(err), 0);

        // Bounce: 2-cycle high pulses never reach DEBOUNCE.
        clear_tally();
        for (int i = 0; i < 20; i++) begin
            set_btn = ((i % 4) < 2);
            step();
        end
        set_btn = 1'b0;
        repeat (15) step();
        check_val("bounce_s_count", n_s, 0);

        // Simultaneous set and clear: clear wins.
        clear_tally();
        set_btn = 1'b1;
        clr_btn = 1'b1;
        repeat (30) step();
        set_btn = 1'b0;
        clr_btn = 1'b0;
        repeat (10) step();
        check_val("prio_r_count", n_r, 1);
        check_val("prio_r_latency", first_r, 7);
        check_val("prio_s_count", n_s, 0);
        check_val("prio_hold_cycles", n_hold, 0);

        // Retrigger: second press lands in HOLD with the timer at 10.
        clear_tally();
        set_btn = 1'b1;
        repeat (6) step();
        set_btn = 1'b0;
        repeat (6) step();
        set_btn = 1'b1;
        repeat (30) step();
        set_btn = 1'b0;
        repeat (10) step();
        check_val("retrig_s_count", n_s, 1);
        check_val("retrig_r_cycle", first_r, 35);
        check_val("retrig_r_count", n_r, 1);
        check_val("retrig_hold_cycles", n_hold, 27);

        // Stuck-low feedback.
        clear_tally();
        force_q0 = 1'b1;
        set_btn = 1'b1;
        repeat (8) step();
        check_val("fault_err_first_hold", int'(err), 0);
        step();
        check_val("fault_err_set", int'(err), 1);
        repeat (31) step();
        set_btn = 1'b0;
        repeat (10) step();
        check_val("fault_r_count", n_r, 1);
        check_val("fault_err_sticky", int'(err), 1);
        force_q0 = 1'b0;
        rst = 1'b1;
        step();
        rst = 1'b0;
        check_val("fault_err_cleared", int'(err), 0);
        repeat (10) step();

        // Randomized buttons, feedback glitches and occasional resets.
        left[0] = 0; left[1] = 0;
        pinv[0] = 1'b0; pinv[1] = 1'b0;
        for (int i = 0; i < 2000; i++) begin
            for (int b = 0; b < 2; b++) begin
                if (left[b] == 0) begin
                    pinv[b] = 1'($urandom_range(0, 1));
                    left[b] = int'($urandom_range(1, 12));
                end
                left[b]--;
            end
            set_btn  = pinv[0];
            clr_btn  = pinv[1];
            force_q0 = ($urandom_range(0, 31) == 0);
            rst      = ($urandom_range(0, 299) == 0);
            step();
        end
        rst = 1'b0;
        force_q0 = 1'b0;
        set_btn = 1'b0;
        clr_btn = 1'b0;
        repeat (5) step();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
